stall_requester: RTL
====================

STALL_REQUESTER -- requirements
Module: stall_requester

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent in each wait state before the request is abandoned.
REQ-002 Parameter REGW, default 5: register-index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 instValid  in  1  decode-stage instruction valid.
REQ-006 instAdv  in  1  decode register loaded a new instruction this cycle.
REQ-007 isMulDiv  in  1  decode instruction is a multi-cycle multiply/divide.
REQ-008 rs1, rs2  in  REGW  decode source registers.
REQ-009 usesRs2  in  1  rs2 is a real operand.
REQ-010 exIsLoad  in  1  execute-stage instruction is a load.
REQ-011 rdEx  in  REGW  execute-stage destination register.
REQ-012 pcEn  in  1  from delay counter; 1 = PC may advance, 0 = delay in progress.
REQ-013 delayEn  out  1  delay request to delay counter; one-cycle high pulse.
REQ-014 hold  out  1  freeze decode/fetch this cycle.
REQ-015 stallCause  out  2  00 none, 01 load-use, 10 mul/div, 11 timeout.
REQ-016 timeoutErr  out  1  sticky error flag.

Function
REQ-017 loadUse SHALL be instValid & exIsLoad & (rdEx != 0) & (rdEx == rs1 | (usesRs2 & rdEx == rs2)).
REQ-018 mdHaz SHALL be instValid & isMulDiv.
REQ-019 hazard SHALL be (loadUse | mdHaz) & !served.
REQ-020 Priority SHALL be loadUse over mdHaz; the cause SHALL be latched at the IDLE->REQ transition.
REQ-021 FSM states SHALL be IDLE, REQ, WAIT_LOW, WAIT_HIGH.
REQ-022 IDLE: on hazard, go to REQ; otherwise stay in IDLE.
REQ-023 REQ: delayEn = 1 for exactly this one cycle, then go to WAIT_LOW.
REQ-024 WAIT_LOW: on pcEn == 0, go to WAIT_HIGH and reset the timer; on timer == TIMEOUT, go to IDLE with timeout.
REQ-025 WAIT_HIGH: on pcEn == 1, go to IDLE and set served; on timer == TIMEOUT, go to IDLE with timeout.
REQ-026 Timer SHALL clear on entry to WAIT_LOW and WAIT_HIGH, increment each cycle in those states, and saturate at TIMEOUT (no wrap).
REQ-027 A timeout SHALL set timeoutErr (sticky until rst), set served, and drive stallCause = 11 for one cycle.
REQ-028 served SHALL clear on instAdv; if instAdv coincides with the set condition, set wins.
REQ-029 hold SHALL be (state != IDLE) | (state == IDLE & hazard), combinational, giving zero-latency freeze.
REQ-030 stallCause SHALL show the latched cause while state != IDLE, 11 in the timeout cycle, else 00.
REQ-031 Hazards arising in REQ, WAIT_LOW or WAIT_HIGH SHALL be ignored; no request queueing.
REQ-032 delayEn SHALL never be high in two consecutive cycles.
REQ-033 Latency: hazard in cycle N gives hold in cycle N and delayEn in cycle N+1.

Reset
REQ-034 rst SHALL force state IDLE, timer 0, served 0, latched cause 00, and timeoutErr 0.
REQ-035 While rst is high, outputs SHALL be delayEn 0, hold 0, and stallCause 00.
REQ-036 rst asserted mid-handshake SHALL abort the handshake; no delayEn is issued in the following cycle.

Structure
REQ-037 A shared package SHALL hold the state enum, the cause codes (CAUSE_NONE/LOADUSE/MULDIV/TIMEOUT), and the TIMEOUT default.
REQ-038 One sub-module, stall_timer, SHALL implement the saturating clear/increment counter with a done flag.

Verification
REQ-039 Load-use: exIsLoad = 1, rdEx = 5, rs1 = 5, instValid = 1; pcEn drops at N+2 and rises at N+5 -> hold N..N+5, delayEn only at N+1, stallCause 01, served set.
REQ-040 r0 exclusion: rdEx = 0, rs1 = 0, exIsLoad = 1 -> no hold, no delayEn.
REQ-041 Mul/div re-trigger: isMulDiv held 3 handshakes with no instAdv -> exactly one delayEn; after an instAdv pulse -> a second delayEn.
REQ-042 Timeout: pcEn stuck at 1 after delayEn -> return to IDLE after 15 WAIT_LOW cycles, stallCause 11 for one cycle, timeoutErr stays 1.
REQ-043 Priority: loadUse and mdHaz both true -> stallCause 01.
REQ-044 Reset: rst in WAIT_HIGH -> IDLE next cycle, outputs zero, timeoutErr cleared.

Source files
------------

// File: rtl/stall_requester_pkg.sv
// Shared types for the decode-stage stall requester: FSM states, stall cause codes
// and the default wait-state timeout.
package stall_requester_pkg;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_LOW  = 2'b10,
        WAIT_HIGH = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_LOADUSE = 2'b01,
        CAUSE_MULDIV  = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } cause_t;

endpackage

// File: rtl/stall_timer.sv
// Saturating wait-state timer: clears on request, counts up to MAX and holds there.
// Latency: done reflects the registered count, so it is valid the cycle the count reaches MAX.
// Backpressure: none; clear takes priority over inc.
module stall_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == LIMIT);

endmodule

// File: rtl/stall_requester.sv
// Detects load-use and mul/div hazards in decode, freezes the front end and runs a delay handshake.
// Latency: hold is combinational in the hazard cycle; delayEn pulses in the following cycle.
// Backpressure: waits on pcEn low-then-high from the delay counter, abandoning after TIMEOUT cycles.
module stall_requester
    import stall_requester_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int REGW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instValid,
    input  logic            instAdv,
    input  logic            isMulDiv,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic            usesRs2,
    input  logic            exIsLoad,
    input  logic [REGW-1:0] rdEx,
    input  logic            pcEn,
    output logic            delayEn,
    output logic            hold,
    output logic [1:0]      stallCause,
    output logic            timeoutErr
);

    state_t state;
    state_t stateNext;
    cause_t cause;
    logic   served;
    logic   loadUse;
    logic   mdHaz;
    logic   hazard;
    logic   timerClear;
    logic   timerInc;
    logic   timerDone;
    logic   timeoutNow;
    logic   serveNow;

    assign loadUse = instValid & exIsLoad & (rdEx != '0)
                   & ((rdEx == rs1) | (usesRs2 & (rdEx == rs2)));
    assign mdHaz   = instValid & isMulDiv;
    // served masks the instruction that already got its delay until decode advances
    assign hazard  = (loadUse | mdHaz) & ~served;

    stall_timer #(
        .MAX (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timerClear),
        .inc   (timerInc),
        .done  (timerDone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        timerClear = 1'b0;
        timerInc   = 1'b0;
        timeoutNow = 1'b0;
        serveNow   = 1'b0;
        case (state)
            IDLE: begin
                if (hazard) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                stateNext  = WAIT_LOW;
                timerClear = 1'b1;
            end
            WAIT_LOW: begin
                if (!pcEn) begin
                    stateNext  = WAIT_HIGH;
                    timerClear = 1'b1;
                end else if (timerDone) begin
                    stateNext  = IDLE;
                    timeoutNow = 1'b1;
                end else begin
                    timerInc = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (pcEn) begin
                    stateNext = IDLE;
                    serveNow  = 1'b1;
                end else if (timerDone) begin
                    stateNext  = IDLE;
                    timeoutNow = 1'b1;
                end else begin
                    timerInc = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            served     <= 1'b0;
            cause      <= CAUSE_NONE;
            timeoutErr <= 1'b0;
        end else begin
            if (serveNow || timeoutNow) begin
                served <= 1'b1;
            end else if (instAdv) begin
                served <= 1'b0;
            end
            if ((state == IDLE) && hazard) begin
                cause <= loadUse ? CAUSE_LOADUSE : CAUSE_MULDIV;
            end
            if (timeoutNow) begin
                timeoutErr <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet during reset even though state only resets at the edge
    assign delayEn = ~rst & (state == REQ);
    assign hold    = ~rst & ((state != IDLE) | hazard);

    always_comb begin
        stallCause = CAUSE_NONE;
        if (!rst) begin
            if (timeoutNow) begin
                stallCause = CAUSE_TIMEOUT;
            end else if (state != IDLE) begin
                stallCause = cause;
            end
        end
    end

endmodule
